// File: rtl/ecs3_tx_arbiter.sv
// ECS3 transmitter arbiter: round-robin grant, start/busy sequencing
// and an inter-frame gap so the far-end idle delimiter always expires.
module ecs3_tx_arbiter #(
  parameter int N_REQ      = 4,
  parameter int GAP_CYCLES = 16,
  parameter int START_TO   = 32
) (
  input  logic                clk,
  input  logic                nRST,
  input  logic [N_REQ-1:0]    req,
  input  logic [16*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]    gnt,
  output logic [N_REQ-1:0]    done,
  output logic                err,
  output logic [15:0]         tx_data,
  output logic                tx_start,
  input  logic                tx_busy,
  output logic                arb_busy
);

  localparam int PW   = $clog2(N_REQ);
  localparam int CMAX = (GAP_CYCLES > START_TO) ? GAP_CYCLES : START_TO;
  localparam int CW   = $clog2(CMAX) + 1;

  localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(START_TO - 1);
  localparam logic [PW-1:0] PTR_LAST = PW'(N_REQ - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_WAIT  = 3'd2,
    S_XFER  = 3'd3,
    S_GAP   = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [15:0]      data_q, data_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [N_REQ-1:0] req_rot;
  logic             win_vld;
  logic [PW-1:0]    win_idx;
  logic [PW:0]      win_sum;
  logic [15:0]      win_data;
  logic             fin;

  // Rotate so bit 0 is the requester at the pointer; first set bit wins.
  assign req_rot = N_REQ'({req, req} >> ptr_q);

  always_comb begin
    win_vld  = 1'b0;
    win_idx  = '0;
    win_sum  = '0;
    win_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!win_vld && req_rot[i]) begin
        win_vld = 1'b1;
        win_sum = {1'b0, ptr_q} + (PW+1)'(i);
        if (win_sum >= (PW+1)'(N_REQ)) begin
          win_sum = win_sum - (PW+1)'(N_REQ);
        end
        win_idx = win_sum[PW-1:0];
      end
    end
    for (int j = 0; j < N_REQ; j++) begin
      if (win_idx == PW'(j)) begin
        win_data = req_data[16*j +: 16];
      end
    end
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state_q <= S_IDLE;
      gnt_q   <= '0;
      ptr_q   <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    ptr_d    = ptr_q;
    data_d   = data_q;
    cnt_d    = cnt_q;
    tx_start = 1'b0;
    err      = 1'b0;
    fin      = 1'b0;
    case (state_q)
      S_IDLE: begin
        gnt_d = '0;
        if (win_vld) begin
          gnt_d   = N_REQ'(1) << win_idx;
          data_d  = win_data;
          ptr_d   = (win_idx == PTR_LAST) ? '0 : win_idx + PW'(1);
          state_d = S_START;
        end
      end
      S_START: begin
        tx_start = 1'b1;
        cnt_d    = '0;
        state_d  = S_WAIT;
      end
      S_WAIT: begin
        if (tx_busy) begin
          state_d = S_XFER;
        end else if (cnt_q == TO_LAST) begin
          fin     = 1'b1;
          err     = 1'b1;
          gnt_d   = '0;
          cnt_d   = '0;
          state_d = S_GAP;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_XFER: begin
        if (!tx_busy) begin
          fin     = 1'b1;
          gnt_d   = '0;
          cnt_d   = '0;
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        gnt_d = '0;
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        gnt_d   = '0;
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  assign gnt      = gnt_q;
  assign done     = fin ? gnt_q : '0;
  assign tx_data  = data_q;
  assign arb_busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_ecs3_tx_arbiter.sv
// Self-checking bench for ecs3_tx_arbiter: transaction-level model,
// per-cycle compare, directed scenarios and a randomized soak.
module tb_ecs3_tx_arbiter;

  localparam int N   = 4;
  localparam int GAP = 16;
  localparam int TO  = 32;

  logic           clk      = 1'b0;
  logic           nRST     = 1'b0;
  logic [N-1:0]   req      = '0;
  logic [16*N-1:0] req_data = '0;
  logic           tx_busy  = 1'b0;
  logic [N-1:0]   gnt;
  logic [N-1:0]   done;
  logic           err;
  logic [15:0]    tx_data;
  logic           tx_start;
  logic           arb_busy;

  ecs3_tx_arbiter #(
    .N_REQ(N), .GAP_CYCLES(GAP), .START_TO(TO)
  ) dut (
    .clk(clk), .nRST(nRST), .req(req), .req_data(req_data),
    .gnt(gnt), .done(done), .err(err), .tx_data(tx_data),
    .tx_start(tx_start), .tx_busy(tx_busy), .arb_busy(arb_busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int ncyc = 0;

  bit fix_mode = 1'b1;
  bit fix_en = 1'b1;
  int fix_d = 2;
  int fix_l = 40;
  int st_cyc = -1000;
  int cur_d = 2;
  int cur_l = 40;
  bit cur_en = 1'b1;

  int gnt_log[$];
  int done_log[$];
  int start_log[$];
  logic [N-1:0] gnt_prev = '0;

  int m_owner = -1;
  int m_age = 0;
  int m_gap = 0;
  int m_ptr = 0;
  bit m_seen = 1'b0;
  logic [15:0] m_data = '0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d act=%0h exp=%0h", nm, ncyc, act, exp);
    end
  endtask

  // Transmitter stand-in: busy for cur_l cycles, cur_d cycles after start.
  always @(posedge clk) begin
    #1;
    tx_busy = cur_en && (ncyc - st_cyc + 1 >= cur_d) &&
              (ncyc - st_cyc + 1 < cur_d + cur_l);
  end

  always @(negedge clk) begin : cmp
    logic [N-1:0] e_gnt;
    logic [N-1:0] e_done;
    logic e_start;
    logic e_err;
    logic e_arb;
    logic fin;
    ncyc++;
    if (!nRST) begin
      m_owner = -1;
      m_age = 0;
      m_gap = 0;
      m_ptr = 0;
      m_seen = 1'b0;
      m_data = '0;
    end
    e_gnt = '0;
    e_done = '0;
    e_start = 1'b0;
    e_err = 1'b0;
    fin = 1'b0;
    if (m_owner >= 0) begin
      e_gnt[m_owner] = 1'b1;
      e_start = (m_age == 0);
      if (m_age >= 1 && !tx_busy && (m_seen || m_age == TO)) begin
        fin = 1'b1;
        e_done = e_gnt;
        e_err = !m_seen;
      end
    end
    e_arb = (m_owner >= 0) || (m_gap > 0);
    chk("gnt", 64'(gnt), 64'(e_gnt));
    chk("done", 64'(done), 64'(e_done));
    chk("err", 64'(err), 64'(e_err));
    chk("tx_start", 64'(tx_start), 64'(e_start));
    chk("arb_busy", 64'(arb_busy), 64'(e_arb));
    chk("tx_data", 64'(tx_data), 64'(m_data));
    chk("onehot", 64'($countones(gnt) <= 1 && $countones(done) <= 1), 64'(1));
    if (nRST) begin
      for (int i = 0; i < N; i++)
        if (gnt[i] && !gnt_prev[i]) gnt_log.push_back(i);
      if (done != 0) done_log.push_back(ncyc);
      if (tx_start) begin
        start_log.push_back(ncyc);
        st_cyc = ncyc;
        if (fix_mode) begin
          cur_d = fix_d;
          cur_l = fix_l;
          cur_en = fix_en;
        end else begin
          cur_d = $urandom_range(1, 6);
          cur_l = $urandom_range(1, 30);
          cur_en = ($urandom % 10) != 0;
        end
      end
      if (m_owner >= 0) begin
        if (fin) begin
          m_owner = -1;
          m_gap = GAP;
        end else begin
          if (m_age >= 1 && tx_busy) m_seen = 1'b1;
          m_age++;
        end
      end else if (m_gap > 0) begin
        m_gap--;
      end else if (req != 0) begin
        for (int k = 0; k < N; k++) begin
          int j;
          j = (m_ptr + k) % N;
          if (m_owner < 0 && req[j]) begin
            m_owner = j;
            m_data = req_data[16*j +: 16];
            m_ptr = (j + 1) % N;
            m_age = 0;
            m_seen = 1'b0;
          end
        end
      end
    end
    gnt_prev = gnt;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic obs();
    @(negedge clk);
    #1;
  endtask

  // kind: 0 done, 1 gnt, 2 idle, 3 err, 4 granted and busy
  task automatic wait_sig(input int kind, input string nm, output int c);
    bit hit;
    hit = 1'b0;
    for (int k = 0; k < 400 && !hit; k++) begin
      obs();
      case (kind)
        0: hit = (done != 0);
        1: hit = (gnt != 0);
        2: hit = !arb_busy;
        3: hit = err;
        4: hit = (gnt != 0) && tx_busy;
        default: hit = 1'b1;
      endcase
    end
    c = ncyc;
    if (!hit) chk({nm, "_timeout"}, 64'(0), 64'(1));
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_gnt"}, 64'(gnt), 64'(0));
    chk({nm, "_done"}, 64'(done), 64'(0));
    chk({nm, "_err"}, 64'(err), 64'(0));
    chk({nm, "_start"}, 64'(tx_start), 64'(0));
    chk({nm, "_busy"}, 64'(arb_busy), 64'(0));
  endtask

  initial begin
    int c0;
    int c1;
    int bad;
    repeat (3) obs();
    chk_zero("rst");
    chk("rst_data", 64'(tx_data), 64'(0));
    step();
    nRST = 1'b1;

    req_data[15:0] = 16'hA5C3;
    req = 4'b0001;
    obs();
    chk("t1_nogrant_yet", 64'(gnt), 64'(0));
    obs();
    chk("t1_gnt", 64'(gnt), 64'(4'b0001));
    chk("t1_data", 64'(tx_data), 64'(16'hA5C3));
    step();
    req = '0;
    wait_sig(0, "t1_done", c0);
    chk("t1_done_bit", 64'(done), 64'(4'b0001));
    chk("t1_starts", 64'(start_log.size()), 64'(1));
    chk("t1_done_lat", 64'(c0 - start_log[0]), 64'(42));
    step();
    req = 4'b0001;
    wait_sig(1, "t1_regnt", c1);
    chk("t1_gap", 64'(c1 - c0), 64'(18));
    step();
    req = '0;
    wait_sig(2, "t1_idle", c0);

    step();
    nRST = 1'b0;
    obs();
    chk_zero("rst2");
    step();
    nRST = 1'b1;

    gnt_log.delete();
    req = 4'b1111;
    for (int k = 0; k < 1000 && gnt_log.size() < 5; k++) obs();
    step();
    req = '0;
    chk("t2_ngrants", 64'(gnt_log.size() >= 5), 64'(1));
    if (gnt_log.size() >= 5) begin
      for (int k = 0; k < 5; k++)
        chk("t2_order", 64'(gnt_log[k]), 64'(k % 4));
    end
    wait_sig(2, "t2_idle", c0);

    fix_en = 1'b0;
    start_log.delete();
    step();
    req = 4'b0100;
    wait_sig(1, "t3_gnt", c0);
    step();
    req = '0;
    wait_sig(3, "t3_err", c1);
    chk("t3_done", 64'(done), 64'(4'b0100));
    chk("t3_starts", 64'(start_log.size()), 64'(1));
    if (start_log.size() > 0)
      chk("t3_to_lat", 64'(c1 - start_log[0]), 64'(32));
    wait_sig(2, "t3_idle", c0);
    fix_en = 1'b1;
    step();
    req = 4'b1001;
    obs();
    obs();
    chk("t3_ptr", 64'(gnt), 64'(4'b1000));
    step();
    req = '0;
    wait_sig(2, "t3_idle2", c0);

    step();
    req_data[31:16] = 16'h1234;
    req = 4'b0010;
    wait_sig(1, "t4_gnt", c0);
    step();
    req_data[31:16] = 16'hFFFF;
    req = '0;
    bad = 0;
    for (int k = 0; k < 200 && done == 0; k++) begin
      obs();
      if (tx_data != 16'h1234) bad++;
    end
    chk("t4_done", 64'(done), 64'(4'b0010));
    chk("t4_stable", 64'(bad), 64'(0));
    wait_sig(2, "t4_idle", c0);

    step();
    req = 4'b1000;
    wait_sig(4, "t5_xfer", c0);
    step();
    req = '0;
    wait_sig(0, "t5_done", c0);
    chk("t5_done_bit", 64'(done), 64'(4'b1000));
    repeat (4) step();
    req = 4'b0001;
    wait_sig(1, "t5_gnt", c1);
    chk("t5_late_gnt", 64'(gnt), 64'(4'b0001));
    chk("t5_late_lat", 64'(c1 - c0), 64'(18));
    step();
    req = '0;
    wait_sig(2, "t5_idle", c0);

    step();
    req = 4'b0010;
    wait_sig(4, "t6_xfer", c0);
    chk("t6_owner", 64'(gnt), 64'(4'b0010));
    #2;
    nRST = 1'b0;
    #1;
    chk_zero("t6_rst");
    req = 4'b0011;
    repeat (2) step();
    nRST = 1'b1;
    wait_sig(1, "t6_gnt", c0);
    chk("t6_first", 64'(gnt), 64'(4'b0001));
    step();
    req = '0;
    wait_sig(2, "t6_idle", c0);

    fix_mode = 1'b0;
    repeat (3000) begin
      step();
      if ($urandom % 6 == 0) req = N'($urandom);
      req_data = {$urandom, $urandom};
    end
    step();
    req = '0;
    wait_sig(2, "rnd_idle", c0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ecs3_tx_arbiter.md
Name: ecs3_tx_arbiter

Overview:
- Shares one ECS3 single-wire transmitter between N_REQ requesters, each with a 16-bit word to send.
- Round-robin arbitration; sequences each frame as start → wait-for-busy → wait-for-idle → inter-frame gap.
- The gap guarantees the far-end receiver's idle-delay delimiter, nominally 8 quiet cycles, expires between frames.
- Sits between client logic and the ECS3 transmitter in the TX path.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- GAP_CYCLES, 16, idle cycles enforced after each frame before the next grant (>=10).
- START_TO, 32, cycles allowed for tx_busy to rise after tx_start before aborting.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- nRST  input  1  asynchronous active-low reset.
- req  input  N_REQ  per-requester request level.
- req_data  input  16*N_REQ  requester i word on bits [16i+15:16i].
- gnt  output  N_REQ  one-hot grant, held for the whole transfer.
- done  output  N_REQ  one-cycle completion pulse to the granted requester.
- err  output  1  one-cycle pulse, coincident with done, on start timeout.
- tx_data  output  16  word presented to the transmitter, stable from grant through done.
- tx_start  output  1  one-cycle start strobe to the transmitter.
- tx_busy  input  1  transmitter busy level.
- arb_busy  output  1  high in every state except IDLE.

Behaviour:
- Clock and reset: one clock, clk. Reset nRST is asynchronous, active-low.
- Reset values: gnt=0, done=0, err=0, tx_start=0, tx_data=0, arb_busy=0, state=IDLE, rr pointer=0, counters=0.
- Reset asserted mid-transfer: same values apply immediately; no done is issued for the aborted transfer.
- States: IDLE, START, WAIT_BUSY, XFER, GAP.
- IDLE, req!=0: select the first set bit scanning from ptr upward with wrap-around.
  - Next edge: gnt[w]=1, tx_data<=req_data slice w, ptr<=(w+1) mod N_REQ, go to START.
  - Latency req→gnt is 1 cycle.
- IDLE, req==0: remain in IDLE.
- START: tx_start=1 for exactly this cycle; clear counter; go to WAIT_BUSY.
- WAIT_BUSY:
  - tx_busy=1 → XFER.
  - Else if counter==START_TO-1 → done[w]=1 and err=1 for one cycle, then GAP.
  - Else increment counter.
- XFER: tx_busy=0 → done[w]=1 for one cycle, then GAP. No timeout in XFER.
- done and gnt timing: done is asserted in the last cycle gnt is high; gnt clears on the following edge.
- GAP:
  - gnt=0; count GAP_CYCLES cycles, then IDLE.
  - Requests arriving during GAP are held off and arbitrated on IDLE entry.
- Data sampling: req_data is sampled only at grant. Later changes do not affect tx_data.
- Dropped request: req falling mid-transfer is ignored; the transfer completes normally with done.
- Held request: req still high after done is treated as a new request and arbitrated under round-robin. It does not win again if other requesters are pending.
- tx_busy already high in the START cycle: legal. It is sampled in WAIT_BUSY, giving immediate → XFER.
- Counter width: clog2(max(GAP_CYCLES, START_TO))+1 bits; the counter saturates and never wraps.
- Exclusivity: at most one bit of gnt and of done is high in any cycle.
- Illegal state: decode to IDLE with gnt=0.

Test Plan:
- Single request: req=0001, req_data[15:0]=16'hA5C3; model busy rises 2 cycles after tx_start, lasts 40 cycles.
  → gnt=0001 one cycle after req; tx_data=A5C3; one tx_start pulse; done[0] on the cycle busy falls; next grant no earlier than 16 cycles later.
- Round-robin: req=1111 held continuously.
  → grant order 0,1,2,3,0; each done followed by >=16-cycle gap; never two bits of gnt high.
- Start timeout: req=0100, tx_busy tied 0.
  → tx_start once; done[2]=1 and err=1 exactly 32 cycles after leaving START; GAP then IDLE; ptr=3.
- Data stability: req_data[31:16] changes from 1234 to FFFF one cycle after gnt[1].
  → tx_data stays 1234 until done[1].
- Dropped request and late arrival: req[3] drops mid-XFER; req[0] rises during GAP.
  → done[3] still issued; gnt[0] exactly 1 cycle after GAP completes.
- Reset mid-transfer: nRST=0 during XFER of requester 1.
  → gnt, done, err, tx_start, arb_busy all 0 asynchronously; ptr=0; after release req=0011 grants requester 0 first.
